// File: rtl/traffic_phase_sched.sv
// rtl/traffic_phase_sched.sv - demand-actuated NS/EW phase scheduler with ped walk and ack
// Optional feature macro: EMERGENCY_PREEMPT_EN (adds i_emg / i_emg_axis preemption)
module traffic_phase_sched #(
   parameter int MIN_GREEN = 20,
   parameter int MAX_GREEN = 40,
   parameter int YELLOW    = 2,
   parameter int ALL_RED   = 1,
   parameter int PED_WALK  = 14,
   parameter int PED_FLASH = 6
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_start,
   input  logic [3:0] i_car_req,
   input  logic [3:0] i_ped_req,
`ifdef EMERGENCY_PREEMPT_EN
   input  logic       i_emg,
   input  logic       i_emg_axis,
`endif
   output logic [1:0] o_state,
   output logic       o_axis,
   output logic [6:0] o_timer,
   output logic [1:0] o_ns_car,
   output logic [1:0] o_ew_car,
   output logic [1:0] o_ns_ped,
   output logic [1:0] o_ew_ped,
   output logic [3:0] o_ped_ack
);

   localparam logic [1:0] S_IDLE    = 2'b00;
   localparam logic [1:0] S_GREEN   = 2'b01;
   localparam logic [1:0] S_YELLOW  = 2'b10;
   localparam logic [1:0] S_ALL_RED = 2'b11;

   localparam logic [6:0] C_MIN      = 7'(MIN_GREEN);
   localparam logic [6:0] C_MAX      = 7'(MAX_GREEN);
   localparam logic [6:0] C_YELLOW   = 7'(YELLOW);
   localparam logic [6:0] C_ALL_RED  = 7'(ALL_RED);
   localparam logic [6:0] C_WALK     = 7'(PED_WALK);
   localparam logic [6:0] C_WALK_END = 7'(PED_WALK + PED_FLASH);

   logic [1:0] r_state;
   logic       r_axis;
   logic [6:0] r_timer;
   logic [3:0] r_latch;
   logic       r_served;
   logic       r_preempt;
   logic [3:0] r_ack;
   logic [1:0] r_ns_car, r_ew_car, r_ns_ped, r_ew_ped;

   logic [1:0] w_state_n;
   logic       w_axis_n;
   logic [6:0] w_timer_n;
   logic [3:0] w_latch_n;
   logic [3:0] w_ack_n;
   logic       w_served_n;
   logic       w_preempt_n;
   logic [1:0] w_ns_car_n, w_ew_car_n, w_ns_ped_n, w_ew_ped_n, w_ped_n;
   logic [3:0] w_own_mask;
   logic [3:0] w_green_mask;
   logic       w_green_axis;
   logic       w_opp_demand;
   logic       w_own_car;
   logic       w_emg;
   logic       w_emg_axis;

`ifdef EMERGENCY_PREEMPT_EN
   assign w_emg      = i_emg;
   assign w_emg_axis = i_emg_axis;
`else
   assign w_emg      = 1'b0;
   assign w_emg_axis = 1'b0;
`endif

   // Next-state, timer, ped latch and ack sequencing
   always_comb begin
      w_state_n    = r_state;
      w_axis_n     = r_axis;
      w_timer_n    = (r_timer == 7'd127) ? r_timer : r_timer + 7'd1;
      w_latch_n    = r_latch | i_ped_req;
      w_ack_n      = 4'b0000;
      w_served_n   = r_served;
      w_preempt_n  = r_preempt;
      w_own_mask   = r_axis ? 4'b1100 : 4'b0011;
      w_green_axis = w_emg ? w_emg_axis : r_axis;
      w_green_mask = w_green_axis ? 4'b1100 : 4'b0011;
      w_opp_demand = |((i_car_req | r_latch) & ~w_own_mask);
      w_own_car    = |(i_car_req & w_own_mask);
      case (r_state)
         S_IDLE: begin
            w_state_n = S_ALL_RED;
            w_axis_n  = 1'b0;
            w_timer_n = 7'd1;
         end
         S_ALL_RED: begin
            if (r_timer >= C_ALL_RED) begin
               w_state_n   = S_GREEN;
               w_axis_n    = w_green_axis;
               w_timer_n   = 7'd1;
               w_preempt_n = 1'b0;
               // A request arriving on the entry edge is folded into this ack
               if (!(r_preempt || w_emg))
                  w_ack_n = (r_latch | i_ped_req) & w_green_mask;
               w_latch_n  = (r_latch | i_ped_req) & ~w_ack_n;
               w_served_n = |w_ack_n;
            end
         end
         S_GREEN: begin
            if (w_emg && (w_emg_axis != r_axis)) begin
               w_state_n   = S_YELLOW;
               w_timer_n   = 7'd1;
               w_served_n  = 1'b0;
               w_preempt_n = 1'b1;
            end else if (!w_emg && (r_timer >= C_MIN) && w_opp_demand &&
                         (!w_own_car || (r_timer >= C_MAX))) begin
               w_state_n  = S_YELLOW;
               w_timer_n  = 7'd1;
               w_served_n = 1'b0;
            end
         end
         S_YELLOW: begin
            if (r_timer >= C_YELLOW) begin
               w_state_n = S_ALL_RED;
               w_timer_n = 7'd1;
               w_axis_n  = ~r_axis;
            end
         end
         default: begin
            w_state_n = S_IDLE;
            w_timer_n = 7'd1;
         end
      endcase
   end

   // Lamp codes decoded from the next state so they change on the same edge
   always_comb begin
      w_ns_car_n = 2'b11;
      w_ew_car_n = 2'b11;
      w_ns_ped_n = 2'b00;
      w_ew_ped_n = 2'b00;
      w_ped_n    = 2'b00;
      if (w_state_n == S_GREEN) begin
         if (w_axis_n) w_ew_car_n = 2'b01;
         else          w_ns_car_n = 2'b01;
      end else if (w_state_n == S_YELLOW) begin
         if (w_axis_n) w_ew_car_n = 2'b10;
         else          w_ns_car_n = 2'b10;
      end
      if ((w_state_n == S_GREEN) && w_served_n) begin
         if (w_timer_n <= C_WALK)
            w_ped_n = 2'b01;
         else if (w_timer_n <= C_WALK_END)
            w_ped_n = {1'b0, ~w_timer_n[0]};
         if (w_axis_n) w_ew_ped_n = w_ped_n;
         else          w_ns_ped_n = w_ped_n;
      end
   end

   // State registers; i_start low freezes everything except the ack pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_axis    <= 1'b0;
         r_timer   <= 7'd1;
         r_latch   <= 4'b0000;
         r_served  <= 1'b0;
         r_preempt <= 1'b0;
         r_ack     <= 4'b0000;
         r_ns_car  <= 2'b11;
         r_ew_car  <= 2'b11;
         r_ns_ped  <= 2'b00;
         r_ew_ped  <= 2'b00;
      end else if (i_start) begin
         r_state   <= w_state_n;
         r_axis    <= w_axis_n;
         r_timer   <= w_timer_n;
         r_latch   <= w_latch_n;
         r_served  <= w_served_n;
         r_preempt <= w_preempt_n;
         r_ack     <= w_ack_n;
         r_ns_car  <= w_ns_car_n;
         r_ew_car  <= w_ew_car_n;
         r_ns_ped  <= w_ns_ped_n;
         r_ew_ped  <= w_ew_ped_n;
      end else begin
         r_ack     <= 4'b0000;
      end
   end

   assign o_state   = r_state;
   assign o_axis    = r_axis;
   assign o_timer   = r_timer;
   assign o_ns_car  = r_ns_car;
   assign o_ew_car  = r_ew_car;
   assign o_ns_ped  = r_ns_ped;
   assign o_ew_ped  = r_ew_ped;
   assign o_ped_ack = r_ack;

endmodule
